// File: rtl/arrow_fire_ctrl.sv
// Arrow fire controller: synchronized, debounced fire button feeding a READY/WAIT_ACK/FLIGHT/COOLDOWN FSM
// with ammo tracking and timed reload. Press to fire_req takes DEBOUNCE_CYCLES+3 edges.
module arrow_fire_ctrl #(
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned COOLDOWN_CYCLES = 8,
   parameter int unsigned AMMO_MAX        = 3,
   parameter int unsigned RELOAD_CYCLES   = 16,
   parameter int unsigned ACK_TIMEOUT     = 4
) (
   input  logic       sim_clk,
   input  logic       reset_n,
   input  logic       fire_button,
   input  logic       arrow_active,
   output logic       fire_req,
   output logic [2:0] ammo_count,
   output logic       dry_fire,
   output logic       ack_fault,
   output logic [1:0] ctrl_state
);

   typedef enum logic [1:0] {
      S_READY    = 2'd0,
      S_WAIT_ACK = 2'd1,
      S_FLIGHT   = 2'd2,
      S_COOLDOWN = 2'd3
   } state_t;

   localparam logic [7:0] DB_LAST   = 8'(DEBOUNCE_CYCLES - 1);
   localparam logic [7:0] CD_LAST   = 8'(COOLDOWN_CYCLES - 1);
   localparam logic [7:0] RL_LAST   = 8'(RELOAD_CYCLES - 1);
   localparam logic [3:0] TMO_LAST  = 4'(ACK_TIMEOUT - 1);
   localparam logic [2:0] AMMO_FULL = 3'(AMMO_MAX);

   logic       sync1_q, sync2_q;
   logic [1:0] vld_q, vld_d;
   logic       arm_q, arm_d;
   logic       db_q, db_d;
   logic [7:0] db_cnt_q, db_cnt_d;
   logic       db_prev_q;
   logic       press_q, press_d;

   state_t     state_q, state_d;
   logic [3:0] tmo_q, tmo_d;
   logic [7:0] cd_q, cd_d;
   logic       fire_q, fire_d;
   logic       dry_q, dry_d;
   logic       fault_q, fault_d;
   logic       ammo_dec, refund;

   logic [7:0] reload_cnt_q, reload_cnt_d;
   logic       reload_inc;
   logic [2:0] ammo_q, ammo_d;
   logic [3:0] ammo_sum;

   // vld_q marks when sync2_q holds a real sample rather than its reset value;
   // arm_q stays low until the button is genuinely seen released after reset.
   always_comb begin
      vld_d    = {vld_q[0], 1'b1};
      arm_d    = arm_q | (vld_q[1] & ~sync2_q);
      db_d     = db_q;
      db_cnt_d = '0;
      if (sync2_q != db_q) begin
         if (db_cnt_q == DB_LAST) begin
            db_d = sync2_q;
         end else begin
            db_cnt_d = db_cnt_q + 8'd1;
         end
      end
      press_d = db_q & ~db_prev_q & arm_q;
   end

   always_comb begin
      state_d  = state_q;
      tmo_d    = tmo_q;
      cd_d     = cd_q;
      fire_d   = 1'b0;
      dry_d    = 1'b0;
      fault_d  = 1'b0;
      ammo_dec = 1'b0;
      refund   = 1'b0;
      case (state_q)
         S_READY: begin
            tmo_d = '0;
            if (press_q) begin
               if (ammo_q == 3'd0) begin
                  dry_d = 1'b1;
               end else if (!arrow_active) begin
                  fire_d   = 1'b1;
                  ammo_dec = 1'b1;
                  state_d  = S_WAIT_ACK;
               end
            end
         end
         S_WAIT_ACK: begin
            fire_d = 1'b1;
            if (arrow_active) begin
               fire_d  = 1'b0;
               state_d = S_FLIGHT;
            end else if (tmo_q == TMO_LAST) begin
               fire_d  = 1'b0;
               refund  = 1'b1;
               fault_d = 1'b1;
               state_d = S_READY;
            end else begin
               tmo_d = tmo_q + 4'd1;
            end
         end
         S_FLIGHT: begin
            if (!arrow_active) begin
               cd_d    = CD_LAST;
               state_d = S_COOLDOWN;
            end
         end
         S_COOLDOWN: begin
            if (cd_q == 8'd0) begin
               state_d = S_READY;
            end else begin
               cd_d = cd_q - 8'd1;
            end
         end
         default: state_d = S_READY;
      endcase
   end

   // Reload, fire and refund all fold into one saturating sum so any
   // coincidence of them resolves in a single update.
   always_comb begin
      reload_cnt_d = '0;
      reload_inc   = 1'b0;
      if (ammo_q != AMMO_FULL) begin
         if (reload_cnt_q == RL_LAST) begin
            reload_inc = 1'b1;
         end else begin
            reload_cnt_d = reload_cnt_q + 8'd1;
         end
      end
      ammo_sum = {1'b0, ammo_q} + {3'b000, reload_inc} + {3'b000, refund}
               - {3'b000, ammo_dec};
      if (ammo_sum > {1'b0, AMMO_FULL}) begin
         ammo_d = AMMO_FULL;
      end else begin
         ammo_d = ammo_sum[2:0];
      end
   end

   always_ff @(posedge sim_clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q      <= 1'b0;
         sync2_q      <= 1'b0;
         vld_q        <= '0;
         arm_q        <= 1'b0;
         db_q         <= 1'b0;
         db_cnt_q     <= '0;
         db_prev_q    <= 1'b0;
         press_q      <= 1'b0;
         state_q      <= S_READY;
         tmo_q        <= '0;
         cd_q         <= '0;
         fire_q       <= 1'b0;
         dry_q        <= 1'b0;
         fault_q      <= 1'b0;
         reload_cnt_q <= '0;
         ammo_q       <= AMMO_FULL;
      end else begin
         sync1_q      <= fire_button;
         sync2_q      <= sync1_q;
         vld_q        <= vld_d;
         arm_q        <= arm_d;
         db_q         <= db_d;
         db_cnt_q     <= db_cnt_d;
         db_prev_q    <= db_q;
         press_q      <= press_d;
         state_q      <= state_d;
         tmo_q        <= tmo_d;
         cd_q         <= cd_d;
         fire_q       <= fire_d;
         dry_q        <= dry_d;
         fault_q      <= fault_d;
         reload_cnt_q <= reload_cnt_d;
         ammo_q       <= ammo_d;
      end
   end

   assign fire_req   = fire_q;
   assign dry_fire   = dry_q;
   assign ack_fault  = fault_q;
   assign ammo_count = ammo_q;
   assign ctrl_state = state_q;

endmodule

// File: tb/tb_arrow_fire_ctrl.sv
// Scoreboard bench for arrow_fire_ctrl: stimulus pushes expected fire/dry/fault events, a monitor pops them.
module tb_arrow_fire_ctrl;

   // Reload slowed so three shots and a dry fire fit inside one refill period.
   localparam int RL = 100;

   logic       sim_clk      = 1'b0;
   logic       reset_n      = 1'b1;
   logic       fire_button  = 1'b0;
   logic       arrow_active = 1'b0;
   logic       fire_req, dry_fire, ack_fault;
   logic [2:0] ammo_count;
   logic [1:0] ctrl_state;

   arrow_fire_ctrl #(
      .DEBOUNCE_CYCLES(4),
      .COOLDOWN_CYCLES(8),
      .AMMO_MAX(3),
      .RELOAD_CYCLES(RL),
      .ACK_TIMEOUT(4)
   ) dut (
      .sim_clk(sim_clk),
      .reset_n(reset_n),
      .fire_button(fire_button),
      .arrow_active(arrow_active),
      .fire_req(fire_req),
      .ammo_count(ammo_count),
      .dry_fire(dry_fire),
      .ack_fault(ack_fault),
      .ctrl_state(ctrl_state)
   );

   always #5 sim_clk = ~sim_clk;

   int cyc = 0;
   always @(posedge sim_clk) cyc <= cyc + 1;

   typedef struct {
      int         kind;     // 0 fire_req rise, 1 dry_fire, 2 ack_fault
      int         at_edge;
      logic [2:0] ammo;
   } ev_t;
   ev_t sbq[$];

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   task automatic push(input int kind, input int at_edge, input logic [2:0] ammo);
      ev_t e;
      e.kind = kind; e.at_edge = at_edge; e.ammo = ammo;
      sbq.push_back(e);
   endtask

   task automatic take(input int kind);
      ev_t e;
      total++;
      if (sbq.size() == 0) begin
         bad++;
         $display("FAIL unexpected_event: got kind=%0d edge=%0d ammo=%0d want none", kind, cyc, ammo_count);
      end else begin
         e = sbq.pop_front();
         if (e.kind != kind || e.at_edge != cyc || e.ammo !== ammo_count) begin
            bad++;
            $display("FAIL event: got kind=%0d edge=%0d ammo=%0d want kind=%0d edge=%0d ammo=%0d",
                     kind, cyc, ammo_count, e.kind, e.at_edge, e.ammo);
         end
      end
   endtask

   logic fire_prev = 1'b0;
   always @(negedge sim_clk) begin
      if (reset_n) begin
         if (fire_req && !fire_prev) take(0);
         if (dry_fire) take(1);
         if (ack_fault) take(2);
      end
      fire_prev <= fire_req;
   end

   task automatic step(input int n);
      repeat (n) @(negedge sim_clk);
   endtask

   task automatic wait_fire(output int e);
      int k = 0;
      while (!fire_req && k < 30) begin step(1); k++; end
      if (!fire_req) begin
         total++; bad++;
         $display("FAIL wait_fire: got no fire_req by edge %0d want fire_req=1", cyc);
      end
      e = cyc;
   endtask

   task automatic wait_ready();
      int k = 0;
      while (ctrl_state != 2'd0 && k < 30) begin step(1); k++; end
      if (ctrl_state != 2'd0) begin
         total++; bad++;
         $display("FAIL wait_ready: got state=%0d want 0", ctrl_state);
      end
   endtask

   // Button rises now: first sampled next edge N, fire_req expected after edge N+7.
   task automatic press(input logic [2:0] exp_ammo);
      fire_button = 1'b1;
      push(0, cyc + 8, exp_ammo);
   endtask

   task automatic shot(input logic [2:0] exp_ammo, output int e);
      press(exp_ammo);
      wait_fire(e);
      fire_button = 1'b0;
      step(1);
      arrow_active = 1'b1;
      step(5);
      arrow_active = 1'b0;
      wait_ready();
   endtask

   task automatic refill(input string name);
      fire_button  = 1'b0;
      arrow_active = 1'b0;
      step(3 * RL + 20);
      chk({name, "_ammo"}, 32'(ammo_count), 3);
      chk({name, "_state"}, 32'(ctrl_state), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want test completion");
      $fatal(1);
   end

   initial begin
      int e, e1, e2;

      #2 reset_n = 1'b0;
      #1;
      chk("rst_fire", 32'(fire_req), 0);
      chk("rst_dry", 32'(dry_fire), 0);
      chk("rst_fault", 32'(ack_fault), 0);
      chk("rst_state", 32'(ctrl_state), 0);
      chk("rst_ammo", 32'(ammo_count), 3);
      step(3);
      reset_n = 1'b1;
      step(6);

      // Clean press with acknowledge one cycle after fire_req.
      press(2);
      wait_fire(e);
      chk("t1_state_wait", 32'(ctrl_state), 1);
      chk("t1_ammo", 32'(ammo_count), 2);
      step(1);
      arrow_active = 1'b1;
      chk("t1_fire_held", 32'(fire_req), 1);
      step(1);
      chk("t1_fire_drop", 32'(fire_req), 0);
      chk("t1_state_flight", 32'(ctrl_state), 2);
      fire_button = 1'b0;
      step(4);
      arrow_active = 1'b0;
      step(1);
      chk("t1_state_cool", 32'(ctrl_state), 3);
      step(7);
      chk("t1_cool_last", 32'(ctrl_state), 3);
      step(1);
      chk("t1_ready", 32'(ctrl_state), 0);
      refill("t1");

      // Bouncing button: 2-cycle toggles never survive debounce, then stable high.
      for (int i = 0; i < 12; i++) begin
         fire_button = ((i % 4) < 2);
         step(1);
      end
      press(2);
      wait_fire(e);
      step(1);
      arrow_active = 1'b1;
      step(5);
      arrow_active = 1'b0;
      wait_ready();
      step(10);
      chk("t2_ammo", 32'(ammo_count), 2);
      refill("t2");

      // Empty magazine: three shots then a dry fire before any reload.
      shot(2, e1);
      shot(1, e);
      shot(0, e);
      fire_button = 1'b1;
      push(1, cyc + 8, 0);
      step(12);
      chk("t3_state", 32'(ctrl_state), 0);
      chk("t3_ammo", 32'(ammo_count), 0);
      refill("t3");

      // No acknowledge: timeout, refund, fault pulse.
      press(2);
      push(2, cyc + 12, 3);
      wait_fire(e);
      step(3);
      chk("t4_fire_4th", 32'(fire_req), 1);
      step(1);
      chk("t4_fire_off", 32'(fire_req), 0);
      chk("t4_state", 32'(ctrl_state), 0);
      chk("t4_ammo", 32'(ammo_count), 3);
      fire_button = 1'b0;
      step(10);

      // Press while an arrow is still active is ignored.
      arrow_active = 1'b1;
      fire_button  = 1'b1;
      step(15);
      chk("t5_state", 32'(ctrl_state), 0);
      chk("t5_ammo", 32'(ammo_count), 3);
      fire_button  = 1'b0;
      arrow_active = 1'b0;
      step(10);

      // Fire decrement coinciding with reload terminal count.
      shot(2, e1);
      while (cyc < e1 + RL - 8) step(1);
      press(2);
      wait_fire(e2);
      chk("t6_edge", 32'(e2), 32'(e1 + RL));
      chk("t6_ammo", 32'(ammo_count), 2);
      chk("t6_reload_cnt", 32'(dut.reload_cnt_q), 0);
      fire_button = 1'b0;
      step(1);
      arrow_active = 1'b1;
      step(5);
      arrow_active = 1'b0;
      wait_ready();
      while (cyc < e2 + RL - 1) step(1);
      chk("t6_before_reload", 32'(ammo_count), 2);
      step(1);
      chk("t6_after_reload", 32'(ammo_count), 3);
      step(5);

      // Reset mid-flight with button held.
      press(2);
      wait_fire(e);
      step(1);
      arrow_active = 1'b1;
      step(3);
      chk("t7_in_flight", 32'(ctrl_state), 2);
      #2 reset_n = 1'b0;
      #1;
      chk("t7_rst_fire", 32'(fire_req), 0);
      chk("t7_rst_state", 32'(ctrl_state), 0);
      chk("t7_rst_ammo", 32'(ammo_count), 3);
      chk("t7_rst_dry", 32'(dry_fire), 0);
      chk("t7_rst_fault", 32'(ack_fault), 0);
      step(2);
      reset_n      = 1'b1;
      arrow_active = 1'b0;
      step(25);
      chk("t7_held_state", 32'(ctrl_state), 0);
      chk("t7_held_ammo", 32'(ammo_count), 3);
      fire_button = 1'b0;
      step(10);
      shot(2, e);
      step(5);

      total++;
      if (sbq.size() != 0) begin
         bad++;
         $display("FAIL leftover_events: got %0d pending want 0", sbq.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
